// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder controller driving one shared full_adder cell, LSB first
// Ports: clk, rst_n (async active-low); start/a/b/cin request; fa_x/fa_y/fa_c to full_adder,
//        fa_s/fa_co from full_adder; busy (RUN), done (one-cycle pulse), sum/cout result registers
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic carry_r;
    logic [CW-1:0] cnt;
    // busy is high exactly in RUN, so it gates the full_adder inputs to 0 elsewhere
    assign fa_x = busy & a_sh[0];
    assign fa_y = busy & b_sh[0];
    assign fa_c = busy & carry_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    carry_r <= cin;
                    cnt     <= '0;
                    acc     <= '0;
                    busy    <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    acc     <= {fa_s, acc[WIDTH-1:1]};
                    carry_r <= fa_co;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {fa_s, acc[WIDTH-1:1]};
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized self-checking bench for serial_adder_ctrl against an arithmetic model
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic cin = 1'b0;
    logic fa_x, fa_y, fa_c, fa_s, fa_co, busy, done, cout;
    logic [7:0] sum;
    int checks = 0, errors = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .fa_x(fa_x), .fa_y(fa_y), .fa_c(fa_c), .fa_s(fa_s), .fa_co(fa_co),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    // the shared full_adder cell
    assign {fa_co, fa_s} = {1'b0, fa_x} + {1'b0, fa_y} + {1'b0, fa_c};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tc, input string tag);
        int n;
        logic [8:0] exp;
        exp = 9'(ta) + 9'(tb2) + 9'(tc);
        @(negedge clk);
        a = ta; b = tb2; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 8);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_result"}, {cout, sum}, exp);
        @(negedge clk);
        chk({tag, "_done_clear"}, done, 0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [8:0] held;
        int last, pulses;
        logic prev_done;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", {cout, sum}, 0);
        chk("rst_fa", {fa_x, fa_y, fa_c}, 0);
        rst_n = 1'b1;

        do_op(8'h00, 8'h00, 1'b0, "zero");
        do_op(8'hFF, 8'h01, 1'b0, "ff_1");
        do_op(8'hA5, 8'h5A, 1'b1, "a5_5a");

        // fa_x serial stream, operand change and ignored start during RUN, result held until done
        pat = 8'h3C;
        held = {cout, sum};
        @(negedge clk);
        a = pat; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fa_x_bit%0d", i), fa_x, pat[i]);
            chk($sformatf("hold_bit%0d", i), {cout, sum}, held);
            if (i == 2) begin a = 8'hFF; start = 1'b1; end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        chk("mid_done", done, 1);
        chk("mid_result", {cout, sum}, 9'h04B);
        @(negedge clk);
        chk("mid_no_restart", busy, 0);

        // reset during the 4th RUN cycle
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", {cout, sum}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_done", done, 0);
        end
        rst_n = 1'b1;
        do_op(8'h80, 8'h80, 1'b0, "post_rst");

        // start held high: done every 10 cycles, busy low between operations
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        last = -1; pulses = 0; prev_done = 1'b0;
        for (int i = 0; i < 55; i++) begin
            @(negedge clk);
            if (prev_done) chk("b2b_idle_busy", busy, 0);
            if (done) begin
                pulses++;
                chk("b2b_result", {cout, sum}, 9'h002);
                chk("b2b_done_busy", busy, 0);
                if (last >= 0) chk("b2b_period", i - last, 10);
                last = i;
            end
            prev_done = done;
        end
        start = 1'b0;
        chk("b2b_pulses", pulses >= 4, 1);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 200; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
